// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM encoding, default width and
// the mapping from raw SCK rise/fall strobes to sample/shift strobes.
package spi_pkg;

   localparam int unsigned DataWidthDefault = 8;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RX   = 3'd1,
      ARM  = 3'd2,
      TX   = 3'd3,
      DONE = 3'd4
   } state_t;

   typedef struct packed {
      logic sample;
      logic shift;
   } edge_t;

   // Leading edge leaves the idle level; CPha picks which edge samples.
   function automatic edge_t edge_decode(input logic cpol, input logic cpha,
                                         input logic rise, input logic fall);
      edge_t e;
      logic  leading;
      logic  trailing;
      leading  = cpol ? fall : rise;
      trailing = cpol ? rise : fall;
      e.sample = cpha ? trailing : leading;
      e.shift  = cpha ? leading : trailing;
      return e;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain for an asynchronous pin followed by a registered
// rise/fall detector; strobes appear Stages+1 cycles after the pin moves.
module spi_sync_edge #(
   parameter int unsigned Stages   = 2,
   parameter logic        ResetVal = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [Stages-1:0] chain;
   logic              prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= {Stages{ResetVal}};
         prev  <= ResetVal;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[Stages-2:0], din};
         prev  <= chain[Stages-1];
         rise  <= chain[Stages-1] & ~prev;
         fall  <= ~chain[Stages-1] & prev;
      end
   end

   assign sync = chain[Stages-1];

endmodule

// File: rtl/spi_slave_cu.sv
// SPI slave: receives a command byte on MOSI, then returns the buffered
// response byte on MISO within the same SS_n frame.
module spi_slave_cu
   import spi_pkg::*;
#(
   parameter int unsigned DataWidth  = DataWidthDefault,
   parameter int unsigned SyncStages = 2
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 CPol,
   input  logic                 CPha,
   input  logic                 SCK,
   input  logic                 SS_n,
   input  logic                 MOSI,
   output logic                 MISO,
   output logic                 MisoEn,
   input  logic [DataWidth-1:0] TxData,
   input  logic                 TxValid,
   output logic                 TxReady,
   output logic [DataWidth-1:0] RxData,
   output logic                 RxValid,
   output logic                 Busy,
   output logic                 Underrun,
   output logic                 Abort,
   output logic [2:0]           State
);

   localparam int unsigned     CntW    = $clog2(DataWidth + 1);
   localparam logic [CntW-1:0] LastBit = CntW'(DataWidth - 1);

   state_t                state;
   logic [CntW-1:0]       cnt;
   logic [DataWidth-2:0]  rx_sr;
   logic [DataWidth-1:0]  tx_sr;
   logic [DataWidth-1:0]  tx_buf;
   logic                  buf_full;
   logic                  cpol_l;
   logic                  cpha_l;
   logic                  sck_sync;
   logic                  sck_rise;
   logic                  sck_fall;
   logic                  ss_sync;
   logic                  ss_rise;
   logic                  ss_fall;
   logic [SyncStages-1:0] mosi_chain;
   logic                  mosi_sync;
   edge_t                 sck_edge;

   spi_sync_edge #(.Stages(SyncStages), .ResetVal(1'b0)) u_sck (
      .clk  (Clk),
      .rst  (Rst),
      .din  (SCK),
      .sync (sck_sync),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   // SS_n resets high so leaving reset never looks like a select.
   spi_sync_edge #(.Stages(SyncStages), .ResetVal(1'b1)) u_ss (
      .clk  (Clk),
      .rst  (Rst),
      .din  (SS_n),
      .sync (ss_sync),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   always_ff @(posedge Clk) begin
      if (Rst) mosi_chain <= '0;
      else     mosi_chain <= {mosi_chain[SyncStages-2:0], MOSI};
   end

   assign mosi_sync = mosi_chain[SyncStages-1];
   assign sck_edge  = edge_decode(cpol_l, cpha_l, sck_rise, sck_fall);
   assign TxReady   = ~buf_full;
   assign State     = state;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= IDLE;
         cnt      <= '0;
         rx_sr    <= '0;
         tx_sr    <= '1;
         tx_buf   <= '0;
         buf_full <= 1'b0;
         cpol_l   <= 1'b0;
         cpha_l   <= 1'b0;
         MISO     <= 1'b1;
         MisoEn   <= 1'b0;
         RxData   <= '0;
         RxValid  <= 1'b0;
         Busy     <= 1'b0;
         Underrun <= 1'b0;
         Abort    <= 1'b0;
      end else begin
         RxValid  <= 1'b0;
         Underrun <= 1'b0;
         Abort    <= 1'b0;
         Busy     <= ~ss_sync;

         if (ss_rise && (state == RX || state == ARM || state == TX)) begin
            state  <= IDLE;
            cnt    <= '0;
            Abort  <= 1'b1;
            MISO   <= 1'b1;
            MisoEn <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (ss_fall) begin
                     cpol_l <= CPol;
                     cpha_l <= CPha;
                     cnt    <= '0;
                     state  <= RX;
                  end
               end
               RX: begin
                  if (sck_edge.sample) begin
                     rx_sr <= {rx_sr[DataWidth-3:0], mosi_sync};
                     if (cnt == LastBit) begin
                        RxData  <= {rx_sr, mosi_sync};
                        RxValid <= 1'b1;
                        cnt     <= '0;
                        state   <= ARM;
                     end else begin
                        cnt <= cnt + CntW'(1);
                     end
                  end
               end
               ARM: begin
                  if (sck_sync == cpol_l) begin
                     state    <= TX;
                     cnt      <= '0;
                     MisoEn   <= 1'b1;
                     buf_full <= 1'b0;
                     if (buf_full) begin
                        tx_sr <= tx_buf;
                        MISO  <= tx_buf[DataWidth-1];
                     end else begin
                        tx_sr    <= '1;
                        MISO     <= 1'b1;
                        Underrun <= 1'b1;
                     end
                  end
               end
               TX: begin
                  if (sck_edge.sample) begin
                     if (cnt == LastBit) begin
                        cnt    <= '0;
                        state  <= DONE;
                        MISO   <= 1'b1;
                        MisoEn <= 1'b0;
                     end else begin
                        cnt <= cnt + CntW'(1);
                     end
                  // cnt==0 guard keeps the MSB through the first sample edge.
                  end else if (sck_edge.shift && cnt != '0) begin
                     tx_sr <= {tx_sr[DataWidth-2:0], 1'b1};
                     MISO  <= tx_sr[DataWidth-2];
                  end
               end
               DONE: begin
                  if (ss_rise) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end

         if (TxValid && !buf_full) begin
            tx_buf   <= TxData;
            buf_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_cu.sv
// Bench for spi_slave_cu: a bit-level SPI master drives directed frames while
// a buffer/response model and a per-cycle monitor check the slave.
`timescale 1ns/1ps
module tb_spi_slave_cu;

   localparam int DW    = 8;
   localparam int SS    = 2;
   localparam int H     = 6;
   localparam int SETUP = 8;

   logic          Clk     = 1'b0;
   logic          Rst     = 1'b1;
   logic          CPol    = 1'b0;
   logic          CPha    = 1'b0;
   logic          SCK     = 1'b0;
   logic          SS_n    = 1'b1;
   logic          MOSI    = 1'b0;
   logic [DW-1:0] TxData  = '0;
   logic          TxValid = 1'b0;
   logic          MISO, MisoEn, TxReady, RxValid, Busy, Underrun, Abort;
   logic [DW-1:0] RxData;
   logic [2:0]    State;

   int checks  = 0;
   int errors  = 0;
   int rxv_cnt = 0;
   int und_cnt = 0;
   int abt_cnt = 0;

   logic [7:0] exp_q[$];
   logic       model_full = 1'b0;
   logic [7:0] model_buf  = '0;
   logic [7:0] model_rd   = '0;
   logic       model_und  = 1'b0;
   logic [7:0] ss_hist    = '1;
   logic [7:0] rst_hist   = '1;

   typedef struct {
      logic       pol;
      logic       pha;
      logic       pre;
      logic [7:0] pre_d;
      logic [7:0] mo;
      int         park;
      logic [7:0] exp_rd;
      logic       exp_und;
   } vec_t;

   spi_slave_cu #(.DataWidth(DW), .SyncStages(SS)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .CPol     (CPol),
      .CPha     (CPha),
      .SCK      (SCK),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .MisoEn   (MisoEn),
      .TxData   (TxData),
      .TxValid  (TxValid),
      .TxReady  (TxReady),
      .RxData   (RxData),
      .RxValid  (RxValid),
      .Busy     (Busy),
      .Underrun (Underrun),
      .Abort    (Abort),
      .State    (State)
   );

   // clock / reset history
   always #5 Clk = ~Clk;

   always @(posedge Clk) begin
      ss_hist  <= {ss_hist[6:0], SS_n};
      rst_hist <= {rst_hist[6:0], Rst};
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // per-cycle monitor and scoreboard
   always @(negedge Clk) begin
      if (rst_hist[SS:0] == '0)
         check("busy", Busy, !ss_hist[SS]);
      if (!MisoEn)
         check("miso_idle", MISO, 1'b1);
      if (Underrun) und_cnt++;
      if (Abort)    abt_cnt++;
      if (RxValid) begin
         rxv_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected: actual %0h required none", RxData);
         end else begin
            check("rx_data", RxData, exp_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_miso"},     MISO,     1'b1);
      check({tag, "_misoen"},   MisoEn,   1'b0);
      check({tag, "_txready"},  TxReady,  1'b1);
      check({tag, "_rxdata"},   RxData,   8'h00);
      check({tag, "_rxvalid"},  RxValid,  1'b0);
      check({tag, "_busy"},     Busy,     1'b0);
      check({tag, "_underrun"}, Underrun, 1'b0);
      check({tag, "_abort"},    Abort,    1'b0);
      check({tag, "_state"},    State,    3'd0);
   endtask

   task automatic preload(input logic [7:0] d);
      int t;
      t = 0;
      while (!TxReady && t < 50) begin
         cyc(1);
         t++;
      end
      check("preload_ready", TxReady, 1'b1);
      TxData  = d;
      TxValid = 1'b1;
      cyc(1);
      TxValid = 1'b0;
      check("txready_full", TxReady, 1'b0);
      model_full = 1'b1;
      model_buf  = d;
   endtask

   // One SPI frame: nrx command bits, then 8 response bits unless nrx < 8
   // (abort) or rst_at selects a TX bit at which Rst is pulsed.
   task automatic frame(input logic pol, input logic pha, input logic [7:0] mo,
                        input int nrx, input int park, input int rst_at,
                        output logic [7:0] rd);
      logic m;
      rd = '0;
      if (nrx == 8) begin
         exp_q.push_back(mo);
         model_rd   = model_full ? model_buf : 8'hFF;
         model_und  = !model_full;
         model_full = 1'b0;
      end
      CPol = pol;
      CPha = pha;
      SCK  = pol;
      MOSI = 1'b0;
      cyc(H);
      SS_n = 1'b0;
      cyc(SETUP);
      for (int i = 7; i >= 8 - nrx; i--) begin
         if (!pha) begin
            MOSI = mo[i];
            cyc(H);
            SCK = ~pol;
            cyc((i == 0) ? park : H);
            SCK = pol;
         end else begin
            SCK  = ~pol;
            MOSI = mo[i];
            cyc(H);
            SCK = pol;
            cyc(H);
         end
      end
      if (nrx < 8) begin
         cyc(H);
         SS_n = 1'b1;
         cyc(20);
         return;
      end
      for (int i = 7; i >= 0; i--) begin
         if (7 - i == rst_at) begin
            Rst = 1'b1;
            cyc(1);
            check_reset_outputs("midtx_rst");
            SS_n = 1'b1;
            SCK  = pol;
            cyc(5);
            Rst = 1'b0;
            cyc(5);
            return;
         end
         if (!pha) begin
            cyc(H);
            SCK   = ~pol;
            m     = MISO;
            rd[i] = m;
            cyc(H);
            if (i != 0) check("miso_stable", MISO, m);
            SCK = pol;
         end else begin
            SCK = ~pol;
            cyc(H);
            SCK   = pol;
            m     = MISO;
            rd[i] = m;
            cyc(H);
            if (i != 0) check("miso_stable", MISO, m);
         end
      end
      cyc(H);
      SS_n = 1'b1;
      cyc(20);
   endtask

   task automatic run_vec(input vec_t v);
      logic [7:0] rd;
      int rxv0, und0, abt0;
      if (v.pre) preload(v.pre_d);
      rxv0 = rxv_cnt;
      und0 = und_cnt;
      abt0 = abt_cnt;
      frame(v.pol, v.pha, v.mo, 8, v.park, -1, rd);
      check("rxdata_lit",   RxData, v.mo);
      check("read_lit",     rd, v.exp_rd);
      check("read_model",   rd, model_rd);
      check("rxvalid_once", rxv_cnt - rxv0, 1);
      check("underrun_lit", und_cnt - und0, v.exp_und);
      check("underrun_mdl", und_cnt - und0, model_und);
      check("no_abort",     abt_cnt - abt0, 0);
      check("txready_end",  TxReady, 1'b1);
      check("state_idle",   State, 3'd0);
   endtask

   vec_t vecs[7] = '{
      '{1'b0, 1'b0, 1'b1, 8'h3C, 8'hA5, H,  8'h3C, 1'b0},
      '{1'b0, 1'b1, 1'b1, 8'h3C, 8'hA5, H,  8'h3C, 1'b0},
      '{1'b1, 1'b0, 1'b1, 8'h3C, 8'hA5, H,  8'h3C, 1'b0},
      '{1'b1, 1'b1, 1'b1, 8'h3C, 8'hA5, H,  8'h3C, 1'b0},
      '{1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, H,  8'hFF, 1'b1},
      '{1'b0, 1'b0, 1'b1, 8'hC3, 8'h0F, 40, 8'hC3, 1'b0},
      '{1'b1, 1'b0, 1'b1, 8'h96, 8'hE7, 40, 8'h96, 1'b0}
   };

   initial begin
      logic [7:0] rd;
      int rxv0, abt0;

      Rst = 1'b1;
      cyc(3);
      Rst = 1'b0;
      cyc(1);
      check_reset_outputs("reset");

      foreach (vecs[k]) run_vec(vecs[k]);

      // abort after 5 command bits
      rxv0 = rxv_cnt;
      abt0 = abt_cnt;
      frame(1'b0, 1'b0, 8'hB4, 5, H, -1, rd);
      check("abort_pulse",   abt_cnt - abt0, 1);
      check("abort_no_rxv",  rxv_cnt - rxv0, 0);
      check("abort_state",   State, 3'd0);
      run_vec('{1'b0, 1'b0, 1'b1, 8'h42, 8'h81, H, 8'h42, 1'b0});

      // reset pulsed in the middle of the response
      preload(8'h3C);
      abt0 = abt_cnt;
      frame(1'b0, 1'b0, 8'hA5, 8, H, 3, rd);
      check("rst_no_abort", abt_cnt - abt0, 0);
      run_vec('{1'b1, 1'b1, 1'b1, 8'h99, 8'h66, H, 8'h99, 1'b0});

      cyc(10);
      check("rx_q_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

endmodule
